// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a 4:1 mux: sweeps enabled channels, settles, samples y_in into a snapshot vector.
// Optional build macro SCAN_PARITY_EN adds a registered vec_parity output (XOR of sample_vec).
module mux_scan_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             stop,
  input  logic [3:0]       ch_mask,
  input  logic             y_in,
  output logic             s0,
  output logic             s1,
  output logic             busy,
  output logic [3:0]       sample_vec,
  output logic             vec_valid,
  output logic [7:0]       sweep_cnt
`ifdef SCAN_PARITY_EN
  ,
  output logic             vec_parity
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, LAST} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_mask, w_mask_nxt;
  logic             r_mode, w_mode_nxt;
  logic [3:0]       r_work, w_work_nxt;
  logic [3:0]       r_vec, w_vec_nxt;
  logic             r_valid, w_valid_nxt;
  logic [7:0]       r_sweep, w_sweep_nxt;
  logic [3:0]       w_above;
  logic [3:0]       w_merged;
  logic             w_has_next;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_ch = 2'(i);
    end
  endfunction

  // Enabled channels strictly above the current select; masked ones cost no time.
  assign w_above    = r_mask & (4'b1110 << r_sel);
  assign w_has_next = |w_above;
  assign w_merged   = r_work | (4'(y_in) << r_sel);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_mode_nxt  = r_mode;
    w_work_nxt  = r_work;
    w_vec_nxt   = r_vec;
    w_valid_nxt = 1'b0;
    w_sweep_nxt = r_sweep;
    unique case (r_state)
      IDLE: begin
        if (start && |ch_mask) begin
          w_state_nxt = SETTLE;
          w_mask_nxt  = ch_mask;
          w_mode_nxt  = mode;
          w_sel_nxt   = lowest_ch(ch_mask);
          w_cnt_nxt   = CNT_LOAD;
          w_work_nxt  = '0;
        end
      end
      SETTLE: begin
        if (r_cnt != '0) begin
          if (stop) w_state_nxt = IDLE;
          else      w_cnt_nxt   = r_cnt - CNT_W'(1);
        end else if (w_has_next) begin
          if (stop) begin
            w_state_nxt = IDLE;
          end else begin
            w_sel_nxt  = lowest_ch(w_above);
            w_cnt_nxt  = CNT_LOAD;
            w_work_nxt = w_merged;
          end
        end else begin
          // Final sample of the sweep: publish even if stop arrives now (via LAST).
          w_vec_nxt   = w_merged;
          w_valid_nxt = 1'b1;
          w_sweep_nxt = r_sweep + 8'd1;
          if (stop) begin
            w_state_nxt = LAST;
          end else if (r_mode && |ch_mask) begin
            w_mask_nxt = ch_mask;
            w_sel_nxt  = lowest_ch(ch_mask);
            w_cnt_nxt  = CNT_LOAD;
            w_work_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      LAST:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 2'd0;
      r_cnt   <= '0;
      r_mask  <= 4'd0;
      r_mode  <= 1'b0;
      r_work  <= 4'd0;
      r_vec   <= 4'd0;
      r_valid <= 1'b0;
      r_sweep <= 8'd0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      r_mode  <= w_mode_nxt;
      r_work  <= w_work_nxt;
      r_vec   <= w_vec_nxt;
      r_valid <= w_valid_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

`ifdef SCAN_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_parity <= 1'b0;
    else if (w_valid_nxt) r_parity <= ^w_merged;
  end

  assign vec_parity = r_parity;
`endif

  assign s1         = r_sel[1];
  assign s0         = r_sel[0];
  assign busy       = (r_state != IDLE);
  assign sample_vec = r_vec;
  assign vec_valid  = r_valid;
  assign sweep_cnt  = r_sweep;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a 4:1 mux model feeds y_in, and expected select/busy/vector
// timing is derived per cycle from the sweep schedule (channel j of n sampled at E+S*(j+1)).
module tb_mux_scan_ctrl;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, mode, stop, y_in;
  logic [3:0] ch_mask, mux_in;
  logic       s0, s1, busy, vec_valid;
  logic [3:0] sample_vec;
  logic [7:0] sweep_cnt;
`ifdef SCAN_PARITY_EN
  logic       vec_parity;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_vec  = 4'd0;
  int         exp_sweep = 0;

  mux_scan_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .stop       (stop),
    .ch_mask    (ch_mask),
    .y_in       (y_in),
    .s0         (s0),
    .s1         (s1),
    .busy       (busy),
    .sample_vec (sample_vec),
    .vec_valid  (vec_valid),
    .sweep_cnt  (sweep_cnt)
`ifdef SCAN_PARITY_EN
    ,
    .vec_parity (vec_parity)
`endif
  );

  assign y_in = mux_in[{s1, s0}];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string ctx, input int e_sel, input bit e_busy, input bit e_valid);
    check({ctx, " sel"},   32'({s1, s0}),  32'(e_sel));
    check({ctx, " busy"},  32'(busy),      32'(e_busy));
    check({ctx, " valid"}, 32'(vec_valid), 32'(e_valid));
    check({ctx, " vec"},   32'(sample_vec), 32'(exp_vec));
    check({ctx, " sweep"}, 32'(sweep_cnt), 32'(exp_sweep % 256));
`ifdef SCAN_PARITY_EN
    check({ctx, " parity"}, 32'(vec_parity), 32'(^exp_vec));
`endif
  endtask

  // Called at a negedge with the DUT idle. stop_edge = k means stop is seen at edge E+k (0 = never).
  task automatic run_sweep(input logic [3:0] mask, input logic [3:0] ins, input bit md,
                           input int stop_edge, input bit noisy_start);
    int  chs[$];
    int  n, per, n_cyc, done_sw, base, e_sel;
    bit  e_busy, e_valid;
    for (int i = 0; i < 4; i++) if (mask[i]) chs.push_back(i);
    n     = chs.size();
    per   = SETTLE * n;
    n_cyc = ((stop_edge > per) ? stop_edge : per) + 3;
    base  = exp_sweep;
    mux_in  = ins;
    ch_mask = mask;
    mode    = md;
    start   = 1'b1;
    stop    = 1'b0;
    for (int t = 0; t < n_cyc; t++) begin
      @(negedge clk);
      if (stop_edge > 0 && t >= stop_edge && (stop_edge % per) != 0) begin
        e_busy  = 1'b0;
        e_valid = 1'b0;
        e_sel   = chs[((stop_edge - 1) % per) / SETTLE];
        done_sw = stop_edge / per;
      end else if (stop_edge > 0 && t >= stop_edge) begin
        e_busy  = (t == stop_edge);
        e_valid = (t == stop_edge);
        e_sel   = chs[n - 1];
        done_sw = stop_edge / per;
      end else if (!md && t >= per) begin
        e_busy  = 1'b0;
        e_valid = (t == per);
        e_sel   = chs[n - 1];
        done_sw = 1;
      end else begin
        e_busy  = 1'b1;
        e_valid = (t > 0 && (t % per) == 0);
        e_sel   = chs[(t % per) / SETTLE];
        done_sw = t / per;
      end
      if (e_valid) exp_vec = mask & ins;
      exp_sweep = (base + done_sw) % 256;
      check_outputs($sformatf("m%0h md%0d t%0d", mask, md, t), e_sel, e_busy, e_valid);
      start = e_busy && noisy_start && ($urandom_range(0, 2) == 0);
      if (!md) ch_mask = 4'($urandom);
      stop = (stop_edge > 0 && t + 1 == stop_edge);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; ch_mask = 4'd0; mux_in = 4'd0;
    #12;
    check_outputs("reset", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(4'b1111, 4'b1010, 1'b0, 0, 1'b0);
    check("single vec", 32'(sample_vec), 32'h0000_000a);
    check("single cnt", 32'(sweep_cnt), 32'd1);
    run_sweep(4'b0101, 4'b1111, 1'b0, 0, 1'b0);
    check("skip vec", 32'(sample_vec), 32'h0000_0005);
    run_sweep(4'b1111, 4'b0110, 1'b0, 4, 1'b0);
    check("abort vec", 32'(sample_vec), 32'h0000_0005);
    check("abort cnt", 32'(sweep_cnt), 32'd2);
    run_sweep(4'b1111, 4'b0110, 1'b0, 8, 1'b0);

    start = 1'b1; ch_mask = 4'd0;
    @(negedge clk);
    check("zero mask busy", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("zero mask idle", 32'(busy), 32'd0);

    run_sweep(4'b1011, 4'b1101, 1'b0, 0, 1'b1);

    for (int it = 0; it < 40; it++) begin
      logic [3:0] m;
      bit         md;
      int         per, se;
      m   = 4'($urandom_range(1, 15));
      md  = 1'($urandom_range(0, 1));
      per = SETTLE * $countones(m);
      if (md) se = $urandom_range(1, 4 * per);
      else    se = ($urandom_range(0, 1) == 1) ? $urandom_range(1, per) : 0;
      run_sweep(m, 4'($urandom), md, se, (it % 3) == 0);
    end

    run_sweep(4'b0001, 4'b0001, 1'b1, 2 * (256 - exp_sweep) + 1, 1'b0);
    check("wrap cnt", 32'(sweep_cnt), 32'd0);

    start = 1'b1; ch_mask = 4'b1111; mode = 1'b0; mux_in = 4'b1010;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_vec = 4'd0;
    exp_sweep = 0;
    check_outputs("async rst", 0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post rst", 0, 1'b0, 1'b0);
    run_sweep(4'b1111, 4'b1010, 1'b0, 0, 1'b0);
    check("rerun vec", 32'(sample_vec), 32'h0000_000a);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
